vga_scan_generator: RTL

Produces the VGA raster scan that drives the pixel pipeline. It divides the system clock into a pixel enable and runs horizontal and vertical counters. From those counters it emits DrawX/DrawY, the active-low syncs, the blanking signal, a once-per-frame game tick and a frame counter. It feeds color_mapper, the sprite/wall ROM lookups and the game-state logic (frame_start serves as their frame clock).

---
 rtl/vga_scan_generator.sv | 84 ++++++++
 1 files changed

// File: rtl/vga_scan_generator.sv
// rtl/vga_scan_generator.sv - VGA raster scan: pixel enable, H/V counters, syncs, blank, frame tick
module vga_scan_generator #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        Clk,
  input  logic        Reset_n,
  output logic        pixel_clk,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        hs,
  output logic        vs,
  output logic        blank,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div;
  logic [9:0]       hc;
  logic [9:0]       vc;
  logic [15:0]      fcnt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hc <= '0;
      vc <= '0;
    end else if (pixel_clk) begin
      if (hc == H_LAST) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? 10'd0 : vc + 10'd1;
      end else begin
        hc <= hc + 10'd1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fcnt <= '0;
    end else if (frame_start) begin
      fcnt <= fcnt + 16'd1;
    end
  end

  // All outputs decode registered state only, so they change together with DrawX/DrawY.
  assign pixel_clk   = (div == DIV_LAST);
  assign DrawX       = hc;
  assign DrawY       = vc;
  assign hs          = !((hc >= HS_START) && (hc < HS_END));
  assign vs          = !((vc >= VS_START) && (vc < VS_END));
  assign blank       = (hc < H_VIS) && (vc < V_VIS);
  assign frame_start = pixel_clk && (hc == 10'd0) && (vc == V_VIS);
  assign frame_count = fcnt;

endmodule
